// File: rtl/viterbi_survivor_select.sv
// Add-compare-select over the 4-state K=3 trellis with one shared comparator.
// Ports: clk, rst, valid_in, branch_metric_xxx in; busy, valid_out, decoded_bits, path_metric_out, error_frames, dropped_frames out.
module viterbi_survivor_select #(
  parameter int MW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [MW-1:0]    branch_metric_000,
  input  logic [MW-1:0]    branch_metric_001,
  input  logic [MW-1:0]    branch_metric_010,
  input  logic [MW-1:0]    branch_metric_011,
  input  logic [MW-1:0]    branch_metric_100,
  input  logic [MW-1:0]    branch_metric_101,
  input  logic [MW-1:0]    branch_metric_110,
  input  logic [MW-1:0]    branch_metric_111,
  output logic             busy,
  output logic             valid_out,
  output logic [2:0]       decoded_bits,
  output logic [MW-1:0]    path_metric_out,
  output logic [CNT_W-1:0] error_frames,
  output logic [CNT_W-1:0] dropped_frames
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]    idx;
  logic [MW-1:0] bm [8];
  logic [MW-1:0] bm_in [8];
  logic [MW-1:0] best_metric;
  logic [2:0]    best_bits;

  logic [MW-1:0] c0;
  logic [MW-1:0] c1;
  logic          take1;
  logic [MW-1:0] surv_m;
  logic [2:0]    surv_bits;
  logic          upd;
  logic [MW-1:0] fin_m;
  logic [2:0]    fin_bits;
  logic          accept;
  logic          last;
  logic          drop;

  always_comb begin
    bm_in[0] = branch_metric_000;
    bm_in[1] = branch_metric_001;
    bm_in[2] = branch_metric_010;
    bm_in[3] = branch_metric_011;
    bm_in[4] = branch_metric_100;
    bm_in[5] = branch_metric_101;
    bm_in[6] = branch_metric_110;
    bm_in[7] = branch_metric_111;
  end

  // Both predecessors of end state s=idx differ only in u0.
  always_comb begin
    c0        = bm[{1'b0, idx}];
    c1        = bm[{1'b1, idx}];
    take1     = (c1 < c0);
    surv_m    = take1 ? c1 : c0;
    surv_bits = {take1, idx};
    // Strict less-than keeps the lower end state on ties.
    upd       = (idx == 2'd0) || (surv_m < best_metric);
    fin_m     = upd ? surv_m : best_metric;
    fin_bits  = upd ? surv_bits : best_bits;
  end

  assign accept = (state == IDLE) && valid_in;
  assign last   = (state == SCAN) && (idx == 2'd3);
  assign drop   = (state == SCAN) && valid_in;
  assign busy   = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (valid_in) state_nxt = SCAN;
      SCAN: if (idx == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      best_metric     <= '0;
      best_bits       <= '0;
      valid_out       <= 1'b0;
      decoded_bits    <= '0;
      path_metric_out <= '0;
      error_frames    <= '0;
      dropped_frames  <= '0;
      for (int i = 0; i < 8; i++) bm[i] <= '0;
    end else begin
      valid_out <= 1'b0;
      if (accept) begin
        idx <= '0;
        for (int i = 0; i < 8; i++) bm[i] <= bm_in[i];
      end
      if (state == SCAN) begin
        idx         <= idx + 2'd1;
        best_metric <= fin_m;
        best_bits   <= fin_bits;
      end
      if (last) begin
        valid_out       <= 1'b1;
        decoded_bits    <= fin_bits;
        path_metric_out <= fin_m;
        if (fin_m != '0 && error_frames != '1)
          error_frames <= error_frames + CNT_W'(1);
      end
      if (drop && dropped_frames != '1)
        dropped_frames <= dropped_frames + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_viterbi_survivor_select.sv
// Directed bench for viterbi_survivor_select.
// Runs a default-width instance and a CNT_W=2 instance on shared stimulus.
module tb_viterbi_survivor_select;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [3:0] bm [8];

  logic       busy;
  logic       valid_out;
  logic [2:0] decoded_bits;
  logic [3:0] path_metric_out;
  logic [7:0] error_frames;
  logic [7:0] dropped_frames;

  logic       busy_s;
  logic       valid_out_s;
  logic [2:0] decoded_bits_s;
  logic [3:0] path_metric_out_s;
  logic [1:0] error_frames_s;
  logic [1:0] dropped_frames_s;

  int checks;
  int failures;

  viterbi_survivor_select dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .branch_metric_000(bm[0]),
    .branch_metric_001(bm[1]),
    .branch_metric_010(bm[2]),
    .branch_metric_011(bm[3]),
    .branch_metric_100(bm[4]),
    .branch_metric_101(bm[5]),
    .branch_metric_110(bm[6]),
    .branch_metric_111(bm[7]),
    .busy(busy),
    .valid_out(valid_out),
    .decoded_bits(decoded_bits),
    .path_metric_out(path_metric_out),
    .error_frames(error_frames),
    .dropped_frames(dropped_frames)
  );

  viterbi_survivor_select #(.CNT_W(2)) dut_s (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .branch_metric_000(bm[0]),
    .branch_metric_001(bm[1]),
    .branch_metric_010(bm[2]),
    .branch_metric_011(bm[3]),
    .branch_metric_100(bm[4]),
    .branch_metric_101(bm[5]),
    .branch_metric_110(bm[6]),
    .branch_metric_111(bm[7]),
    .busy(busy_s),
    .valid_out(valid_out_s),
    .decoded_bits(decoded_bits_s),
    .path_metric_out(path_metric_out_s),
    .error_frames(error_frames_s),
    .dropped_frames(dropped_frames_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 8; i++) bm[i] = v;
  endtask

  // Accept at E0, then E1..E4; checks busy and no early valid_out.
  task automatic run_frame(input string tag);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk({tag, "_busy_e0"}, busy, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk({tag, "_vo_early"}, valid_out, 0);
    end
    tick();
    chk({tag, "_vo"}, valid_out, 1);
    chk({tag, "_busy_e4"}, busy, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    fill(4'd0);
    tick();
    tick();
    chk("rst_vo", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bits", decoded_bits, 0);
    chk("rst_pm", path_metric_out, 0);
    chk("rst_err", error_frames, 0);
    chk("rst_drop", dropped_frames, 0);
    rst = 1'b0;
    tick();

    // Unique minimum at 101.
    fill(4'd7);
    bm[5] = 4'd0;
    run_frame("uniq");
    chk("uniq_bits", decoded_bits, 3'b101);
    chk("uniq_pm", path_metric_out, 0);
    chk("uniq_err", error_frames, 0);
    tick();
    chk("uniq_vo_pulse", valid_out, 0);
    chk("uniq_hold", decoded_bits, 3'b101);

    // All equal: u0 tie and state tie both pick lowest.
    fill(4'd5);
    run_frame("eq");
    chk("eq_bits", decoded_bits, 3'b000);
    chk("eq_pm", path_metric_out, 5);
    chk("eq_err", error_frames, 1);
    chk("eq_drop", dropped_frames, 0);
    tick();

    // Pair tie at s=10, state tie with s=11.
    fill(4'd9);
    bm[2] = 4'd2;
    bm[6] = 4'd2;
    bm[3] = 4'd2;
    run_frame("tie");
    chk("tie_bits", decoded_bits, 3'b010);
    chk("tie_pm", path_metric_out, 2);
    chk("tie_err", error_frames, 2);
    tick();

    // Drop: accept A at E0, pulse B at E2, accept C at E5.
    fill(4'd6);
    bm[4] = 4'd1;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("drp_busy_e0", busy, 1);
    tick();
    chk("drp_busy_e1", busy, 1);
    fill(4'd0);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("drp_busy_e2", busy, 1);
    chk("drp_vo_e2", valid_out, 0);
    chk("drp_cnt_e2", dropped_frames, 1);
    tick();
    chk("drp_busy_e3", busy, 1);
    chk("drp_vo_e3", valid_out, 0);
    tick();
    chk("drp_vo", valid_out, 1);
    chk("drp_bits", decoded_bits, 3'b100);
    chk("drp_pm", path_metric_out, 1);
    chk("drp_cnt", dropped_frames, 1);
    chk("drp_err", error_frames, 3);
    fill(4'd3);
    bm[7] = 4'd0;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("drp_e5_vo", valid_out, 0);
    chk("drp_e5_busy", busy, 1);
    tick();
    tick();
    tick();
    chk("drp_c_vo_early", valid_out, 0);
    tick();
    chk("drp_c_vo", valid_out, 1);
    chk("drp_c_bits", decoded_bits, 3'b111);
    chk("drp_c_pm", path_metric_out, 0);
    chk("drp_c_err", error_frames, 3);
    chk("drp_c_drop", dropped_frames, 1);
    tick();

    // Reset in the middle of SCAN.
    fill(4'd6);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_vo", valid_out, 0);
    chk("mid_busy", busy, 0);
    chk("mid_bits", decoded_bits, 0);
    chk("mid_pm", path_metric_out, 0);
    chk("mid_err", error_frames, 0);
    chk("mid_drop", dropped_frames, 0);
    fill(4'd4);
    bm[7] = 4'd1;
    run_frame("post");
    chk("post_bits", decoded_bits, 3'b111);
    chk("post_pm", path_metric_out, 1);
    chk("post_err", error_frames, 1);
    tick();

    // Saturation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fill(4'd1);
    for (int f = 0; f < 5; f++) begin
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      tick();
      tick();
    end
    chk("sat_vo", valid_out, 1);
    chk("sat_err8", error_frames, 5);
    chk("sat_err2", error_frames_s, 3);
    chk("sat_vo_s", valid_out_s, 1);
    // Held valid_in: accepted once, then 4 drops (E1..E4).
    tick();
    valid_in = 1'b1;
    tick();
    chk("sat_hold_busy", busy, 1);
    for (int i = 0; i < 4; i++) tick();
    valid_in = 1'b0;
    chk("sat_hold_vo", valid_out, 1);
    chk("sat_drop4", dropped_frames, 4);
    // One more drop inside the next frame.
    valid_in = 1'b1;
    tick();
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    chk("sat_drop8", dropped_frames, 5);
    chk("sat_drop2", dropped_frames_s, 3);
    chk("sat_err8b", error_frames, 7);
    chk("sat_err2b", error_frames_s, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
